// File: rtl/usb_host_auth_resp_gen.sv
// USB host-side Type-C authentication responder: CC attach/detach sequencing, table-driven replies, timeout supervision.
// Define HOST_HDR_CHECK_EN to build the controller message header check that drives hdr_err.
module usb_host_auth_resp_gen #(
  parameter int unsigned MSG_LEN    = 2079,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESP_LAT   = 3,
  parameter int unsigned ATTACH_DLY = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       attach_cmd,
  input  logic                       detach_cmd,
  input  logic                       orient,
  input  logic                       tbl_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   tbl_wr_addr,
  input  logic [MSG_LEN-1:0]         tbl_wr_data,
  input  logic                       resp_req_out,
  input  logic [MSG_LEN-1:0]         auth_msg_resp_out,
  output logic [MSG_LEN-1:0]         auth_msg_resp_in,
  output logic                       resp_req_in,
  output logic                       Ack_out_resp,
  output logic                       CC1,
  output logic                       CC2,
  output logic [MSG_LEN-1:0]         rx_msg,
  output logic [15:0]                rx_cnt,
  output logic                       timeout_err,
  output logic                       hdr_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CMAX = (TIMEOUT > ATTACH_DLY)
                               ? ((TIMEOUT > RESP_LAT) ? TIMEOUT : RESP_LAT)
                               : ((ATTACH_DLY > RESP_LAT) ? ATTACH_DLY : RESP_LAT);
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    DETACHED,
    ATTACH_WAIT,
    IDLE,
    RESP_WAIT,
    RESP_DRIVE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 orient_q, orient_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [MSG_LEN-1:0]   resp_d;
  logic                 rr_d;
  logic                 ack_d;
  logic                 cc1_d, cc2_d;
  logic [MSG_LEN-1:0]   rx_msg_d;
  logic [15:0]          rx_cnt_d;
  logic                 tmo_d;

  logic [MSG_LEN-1:0]   tbl [DEPTH];
  logic [MSG_LEN-1:0]   tbl_rd;

  always_ff @(posedge clk) begin
    if (tbl_wr_en) begin
      tbl[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  // Same-cycle write to the slot being read is forwarded so the driven reply tracks it next cycle.
  always_comb begin
    tbl_rd = tbl[rd_ptr_q];
    if (tbl_wr_en && (tbl_wr_addr == rd_ptr_q)) begin
      tbl_rd = tbl_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= DETACHED;
      cnt_q            <= '0;
      orient_q         <= 1'b0;
      rd_ptr_q         <= '0;
      auth_msg_resp_in <= '0;
      resp_req_in      <= 1'b0;
      Ack_out_resp     <= 1'b0;
      CC1              <= 1'b0;
      CC2              <= 1'b0;
      rx_msg           <= '0;
      rx_cnt           <= '0;
      timeout_err      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      orient_q         <= orient_d;
      rd_ptr_q         <= rd_ptr_d;
      auth_msg_resp_in <= resp_d;
      resp_req_in      <= rr_d;
      Ack_out_resp     <= ack_d;
      CC1              <= cc1_d;
      CC2              <= cc2_d;
      rx_msg           <= rx_msg_d;
      rx_cnt           <= rx_cnt_d;
      timeout_err      <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    orient_d = orient_q;
    rd_ptr_d = rd_ptr_q;
    resp_d   = auth_msg_resp_in;
    rr_d     = resp_req_in;
    ack_d    = 1'b0;
    cc1_d    = CC1;
    cc2_d    = CC2;
    rx_msg_d = rx_msg;
    rx_cnt_d = rx_cnt;
    tmo_d    = timeout_err;

    // Detach overrides every other event, including a simultaneous capture or timeout.
    if (detach_cmd && (state_q != DETACHED)) begin
      state_d = DETACHED;
      cnt_d   = '0;
      rr_d    = 1'b0;
      cc1_d   = 1'b0;
      cc2_d   = 1'b0;
    end else begin
      case (state_q)
        DETACHED: begin
          if (attach_cmd && !detach_cmd) begin
            orient_d = orient;
            cnt_d    = '0;
            state_d  = ATTACH_WAIT;
          end
        end
        ATTACH_WAIT: begin
          if (cnt_q == CW'(ATTACH_DLY - 1)) begin
            cnt_d   = '0;
            cc1_d   = ~orient_q;
            cc2_d   = orient_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        IDLE: begin
          if (resp_req_out) begin
            rx_msg_d = auth_msg_resp_out;
            if (rx_cnt != 16'hFFFF) begin
              rx_cnt_d = rx_cnt + 16'd1;
            end
            ack_d   = 1'b1;
            cnt_d   = '0;
            state_d = RESP_WAIT;
          end
        end
        RESP_WAIT: begin
          if (cnt_q == CW'(RESP_LAT - 1)) begin
            resp_d  = tbl_rd;
            rr_d    = 1'b1;
            cnt_d   = '0;
            state_d = RESP_DRIVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RESP_DRIVE: begin
          if (!resp_req_out || (cnt_q == CW'(TIMEOUT - 1))) begin
            if (resp_req_out) begin
              tmo_d = 1'b1;
            end
            rr_d     = 1'b0;
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            resp_d = tbl_rd;
          end
        end
        default: begin
          state_d = DETACHED;
        end
      endcase
    end
  end

`ifdef HOST_HDR_CHECK_EN
  logic hdr_d;

  always_comb begin
    hdr_d = hdr_err;
    if (ack_d && (auth_msg_resp_out[MSG_LEN-1 -: 8] != 8'h01)) begin
      hdr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_err <= 1'b0;
    end else begin
      hdr_err <= hdr_d;
    end
  end
`else
  assign hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_host_auth_resp_gen.sv
// Bench for usb_host_auth_resp_gen: event-timestamp reference model compared every cycle,
// plus directed checks with hand-computed values for attach timing, latency, wrap, timeout and detach.
`timescale 1ns/1ps
module tb_usb_host_auth_resp_gen;
  localparam int unsigned MSG_LEN    = 2079;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned RESP_LAT   = 3;
  localparam int unsigned ATTACH_DLY = 8;
  localparam int unsigned TIMEOUT    = 64;
`ifdef HOST_HDR_CHECK_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef logic [MSG_LEN-1:0] msg_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        attach_cmd = 1'b0;
  logic        detach_cmd = 1'b0;
  logic        orient = 1'b0;
  logic        tbl_wr_en = 1'b0;
  logic [1:0]  tbl_wr_addr = '0;
  msg_t        tbl_wr_data = '0;
  logic        resp_req_out = 1'b0;
  msg_t        auth_msg_resp_out = '0;
  msg_t        auth_msg_resp_in;
  logic        resp_req_in;
  logic        Ack_out_resp;
  logic        CC1;
  logic        CC2;
  msg_t        rx_msg;
  logic [15:0] rx_cnt;
  logic        timeout_err;
  logic        hdr_err;

  int n_chk  = 0;
  int n_pass = 0;

  usb_host_auth_resp_gen #(
    .MSG_LEN   (MSG_LEN),
    .DEPTH     (DEPTH),
    .RESP_LAT  (RESP_LAT),
    .ATTACH_DLY(ATTACH_DLY),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .attach_cmd       (attach_cmd),
    .detach_cmd       (detach_cmd),
    .orient           (orient),
    .tbl_wr_en        (tbl_wr_en),
    .tbl_wr_addr      (tbl_wr_addr),
    .tbl_wr_data      (tbl_wr_data),
    .resp_req_out     (resp_req_out),
    .auth_msg_resp_out(auth_msg_resp_out),
    .auth_msg_resp_in (auth_msg_resp_in),
    .resp_req_in      (resp_req_in),
    .Ack_out_resp     (Ack_out_resp),
    .CC1              (CC1),
    .CC2              (CC2),
    .rx_msg           (rx_msg),
    .rx_cnt           (rx_cnt),
    .timeout_err      (timeout_err),
    .hdr_err          (hdr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk(name, act === exp, act, exp);
  endtask

  function automatic msg_t mk(input logic [7:0] hdr, input logic [31:0] tag);
    msg_t m;
    m = '0;
    for (int i = 0; i < 64; i++) m[i*32 +: 32] = tag ^ 32'(i);
    m[MSG_LEN-1 -: 8] = hdr;
    m[MSG_LEN-9 -: 8] = 8'h10;
    return m;
  endfunction

  // Reference model: tracks link and handshake by cycle timestamps.
  msg_t m_tbl [DEPTH];
  int   cyc, m_att_at, m_resp_at, m_drv_since, m_ptr;
  bit   m_up, m_pend, m_busy, m_drv, m_ori;
  bit   e_cc1, e_cc2, e_rr, e_ack, e_tmo, e_hdr;
  msg_t e_resp, e_rx;
  int   e_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0; m_ptr = 0;
      m_up = 0; m_pend = 0; m_busy = 0; m_drv = 0; m_ori = 0;
      e_cc1 = 0; e_cc2 = 0; e_rr = 0; e_ack = 0; e_tmo = 0; e_hdr = 0;
      e_resp = '0; e_rx = '0; e_cnt = 0;
    end else begin
      cyc++;
      e_ack = 0;
      if (tbl_wr_en) m_tbl[tbl_wr_addr] = tbl_wr_data;
      if (!m_up && !m_pend) begin
        if (attach_cmd && !detach_cmd) begin
          m_pend = 1; m_att_at = cyc + ATTACH_DLY; m_ori = orient;
        end
      end else if (detach_cmd) begin
        m_up = 0; m_pend = 0; m_busy = 0; m_drv = 0;
        e_rr = 0; e_cc1 = 0; e_cc2 = 0;
      end else if (m_pend) begin
        if (cyc == m_att_at) begin
          m_pend = 0; m_up = 1; e_cc1 = !m_ori; e_cc2 = m_ori;
        end
      end else if (m_drv) begin
        if (!resp_req_out || (cyc - m_drv_since == TIMEOUT)) begin
          if (resp_req_out) e_tmo = 1;
          m_drv = 0; e_rr = 0; m_ptr = (m_ptr + 1) % DEPTH;
        end else begin
          e_resp = m_tbl[m_ptr];
        end
      end else if (m_busy) begin
        if (cyc == m_resp_at) begin
          m_busy = 0; m_drv = 1; m_drv_since = cyc;
          e_resp = m_tbl[m_ptr]; e_rr = 1;
        end
      end else if (resp_req_out) begin
        e_rx = auth_msg_resp_out;
        if (e_cnt < 65535) e_cnt++;
        e_ack = 1; m_busy = 1; m_resp_at = cyc + RESP_LAT;
        if (HDR_EN && (auth_msg_resp_out[MSG_LEN-1 -: 8] != 8'h01)) e_hdr = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("CC1", CC1 === e_cc1, 64'(CC1), 64'(e_cc1));
    chk("CC2", CC2 === e_cc2, 64'(CC2), 64'(e_cc2));
    chk("resp_req_in", resp_req_in === e_rr, 64'(resp_req_in), 64'(e_rr));
    chk("Ack_out_resp", Ack_out_resp === e_ack, 64'(Ack_out_resp), 64'(e_ack));
    chk("auth_msg_resp_in", auth_msg_resp_in === e_resp, auth_msg_resp_in[63:0], e_resp[63:0]);
    chk("rx_msg", rx_msg === e_rx, rx_msg[63:0], e_rx[63:0]);
    chk("rx_cnt", rx_cnt === 16'(e_cnt), 64'(rx_cnt), 64'(e_cnt));
    chk("timeout_err", timeout_err === e_tmo, 64'(timeout_err), 64'(e_tmo));
    chk("hdr_err", hdr_err === e_hdr, 64'(hdr_err), 64'(e_hdr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_attach(input logic ori);
    orient = ori; attach_cmd = 1'b1;
    tick();
    attach_cmd = 1'b0; orient = ~ori;
    repeat (ATTACH_DLY) tick();
  endtask

  task automatic do_req(input msg_t ctl, input msg_t exp, input string tag);
    resp_req_out = 1'b1; auth_msg_resp_out = ctl;
    tick();
    lit({tag, "_ack"}, 64'(Ack_out_resp), 64'd1);
    repeat (RESP_LAT - 1) tick();
    lit({tag, "_early"}, 64'(resp_req_in), 64'd0);
    tick();
    lit({tag, "_valid"}, 64'(resp_req_in), 64'd1);
    lit({tag, "_data"}, auth_msg_resp_in[63:0], exp[63:0]);
    resp_req_out = 1'b0;
    tick();
    lit({tag, "_release"}, 64'(resp_req_in), 64'd0);
    tick();
  endtask

  msg_t rsp [DEPTH];
  msg_t e_msg;

  initial begin
    rsp[0] = mk(8'h01, 32'hA0A0_0001);
    rsp[1] = mk(8'h01, 32'hB0B0_0002);
    rsp[2] = mk(8'h01, 32'hC0C0_0003);
    rsp[3] = mk(8'h01, 32'hD0D0_0004);
    e_msg  = mk(8'h01, 32'hE0E0_0005);

    repeat (2) tick();
    lit("rst_cc1", 64'(CC1), 64'd0);
    lit("rst_rr", 64'(resp_req_in), 64'd0);
    lit("rst_cnt", 64'(rx_cnt), 64'd0);
    lit("rst_msg", auth_msg_resp_in[63:0], 64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      tbl_wr_en = 1'b1; tbl_wr_addr = 2'(i); tbl_wr_data = rsp[i];
      tick();
    end
    tbl_wr_en = 1'b0;

    // Attach on CC1: line rises exactly ATTACH_DLY edges after the command edge.
    orient = 1'b0; attach_cmd = 1'b1;
    tick();
    attach_cmd = 1'b0; orient = 1'b1;
    repeat (ATTACH_DLY - 1) tick();
    lit("att_cc1_early", 64'(CC1), 64'd0);
    tick();
    lit("att_cc1", 64'(CC1), 64'd1);
    lit("att_cc2", 64'(CC2), 64'd0);
    detach_cmd = 1'b1;
    tick();
    detach_cmd = 1'b0;
    lit("det_cc1", 64'(CC1), 64'd0);

    do_attach(1'b1);
    lit("att2_cc2", 64'(CC2), 64'd1);
    lit("att2_cc1", 64'(CC1), 64'd0);

    do_req(mk(8'h01, 32'h1000_0000), rsp[0], "req0");
    lit("req0_cnt", 64'(rx_cnt), 64'd1);
    for (int k = 1; k < 5; k++) do_req(mk(8'h01, 32'h1000_0000 + 32'(k)), rsp[k % DEPTH], "seq");
    lit("seq_cnt", 64'(rx_cnt), 64'd5);
    lit("seq_rx", rx_msg[63:0], 64'h1000_0005_1000_0004);
    lit("seq_hdr", 64'(hdr_err), 64'd0);

    // Rewrite the slot currently being driven.
    resp_req_out = 1'b1; auth_msg_resp_out = mk(8'h01, 32'h2000_0000);
    repeat (RESP_LAT + 1) tick();
    lit("wr_drv_old", auth_msg_resp_in[63:0], rsp[1][63:0]);
    tbl_wr_en = 1'b1; tbl_wr_addr = 2'd1; tbl_wr_data = e_msg;
    tick();
    tbl_wr_en = 1'b0;
    lit("wr_drv_new", auth_msg_resp_in[63:0], e_msg[63:0]);
    resp_req_out = 1'b0;
    tick();
    tbl_wr_en = 1'b1; tbl_wr_addr = 2'd1; tbl_wr_data = rsp[1];
    tick();
    tbl_wr_en = 1'b0;

    // Detach while waiting for the response; requests while detached are ignored.
    resp_req_out = 1'b1; auth_msg_resp_out = mk(8'h01, 32'h3000_0000);
    repeat (2) tick();
    detach_cmd = 1'b1;
    tick();
    detach_cmd = 1'b0;
    lit("detw_cc2", 64'(CC2), 64'd0);
    lit("detw_rr", 64'(resp_req_in), 64'd0);
    repeat (5) tick();
    lit("detw_cnt", 64'(rx_cnt), 64'd7);
    resp_req_out = 1'b0;
    attach_cmd = 1'b1; detach_cmd = 1'b1;
    tick();
    attach_cmd = 1'b0; detach_cmd = 1'b0;
    repeat (ATTACH_DLY + 2) tick();
    lit("both_cc1", 64'(CC1), 64'd0);
    lit("both_cc2", 64'(CC2), 64'd0);

    // Asynchronous reset in the middle of a driven response.
    do_attach(1'b0);
    resp_req_out = 1'b1; auth_msg_resp_out = mk(8'h01, 32'h4000_0000);
    repeat (RESP_LAT + 1) tick();
    lit("ar_rr_pre", 64'(resp_req_in), 64'd1);
    reset = 1'b0; resp_req_out = 1'b0;
    #1;
    lit("ar_rr", 64'(resp_req_in), 64'd0);
    lit("ar_cc1", 64'(CC1), 64'd0);
    lit("ar_cnt", 64'(rx_cnt), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Timeout: request held through TIMEOUT cycles of drive, then next slot follows.
    do_attach(1'b0);
    resp_req_out = 1'b1; auth_msg_resp_out = mk(8'h01, 32'h5000_0000);
    repeat (RESP_LAT + 1) tick();
    lit("to_data", auth_msg_resp_in[63:0], rsp[0][63:0]);
    repeat (TIMEOUT - 1) tick();
    lit("to_rr_hold", 64'(resp_req_in), 64'd1);
    lit("to_err_pre", 64'(timeout_err), 64'd0);
    tick();
    resp_req_out = 1'b0;
    lit("to_err", 64'(timeout_err), 64'd1);
    lit("to_rr", 64'(resp_req_in), 64'd0);
    tick();
    do_req(mk(8'h01, 32'h6000_0000), rsp[1], "to_next");

    do_req(mk(8'h02, 32'h7000_0000), rsp[2], "hdr");
    lit("hdr_err", 64'(hdr_err), 64'(HDR_EN));

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_host_auth_resp_gen.md
Name: usb_host_auth_resp_gen

Overview:
- Parametrised, synthesizable successor to the fixed host stimulus model. Emulates the USB host side of the Type-C authentication link.
- Sequences CC1/CC2 attach and detach with a programmable orientation.
- Answers each controller request with the next entry from a loadable DEPTH-slot response table, after a programmable latency.
- Captures each outgoing controller message and supervises the handshake with a timeout.
- Sits between the bench or system harness and the authentication controller.

Parameters:
- MSG_LEN, 2079, message width in bits (8-bit version, 8-bit type, 2063-bit payload).
- DEPTH, 4, number of response table slots (power of 2, ≥2).
- RESP_LAT, 3, cycles from request capture to response valid (≥1).
- ATTACH_DLY, 8, cycles from attach_cmd to CC assertion (≥1).
- TIMEOUT, 64, maximum cycles resp_req_in may stay high without the controller releasing.

Ports:
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-low reset.
- attach_cmd, in, 1, one-cycle pulse that starts attach.
- detach_cmd, in, 1, one-cycle pulse that forces detach.
- orient, in, 1, 0 selects CC1, 1 selects CC2. Sampled on attach_cmd.
- tbl_wr_en, in, 1, response table write strobe.
- tbl_wr_addr, in, $clog2(DEPTH), table write address.
- tbl_wr_data, in, MSG_LEN, table write data.
- resp_req_out, in, 1, controller request, level-sensitive.
- auth_msg_resp_out, in, MSG_LEN, controller message.
- auth_msg_resp_in, out, MSG_LEN, host response message.
- resp_req_in, out, 1, host response valid.
- Ack_out_resp, out, 1, one-cycle pulse when a request is captured.
- CC1, out, 1, CC line 1.
- CC2, out, 1, CC line 2.
- rx_msg, out, MSG_LEN, last captured controller message.
- rx_cnt, out, 16, captured request count, saturates at 16'hFFFF.
- timeout_err, out, 1, sticky; cleared only by reset.
- hdr_err, out, 1, sticky header-check error; see Optional Feature.

Behaviour:
- Reset values: all outputs 0; state DETACHED; rd_ptr 0. Table contents are not reset.
- Response table:
  - Written on any cycle and in any state.
  - A write to the slot currently being driven updates it the next cycle.
- States: DETACHED, ATTACH_WAIT, IDLE, RESP_WAIT, RESP_DRIVE.
- DETACHED:
  - CC1=CC2=0.
  - attach_cmd latches orient and goes to ATTACH_WAIT.
- ATTACH_WAIT:
  - Counts ATTACH_DLY cycles, then goes to IDLE.
  - CC(orient) rises on the same edge the state enters IDLE.
- IDLE, RESP_WAIT, RESP_DRIVE: CC(orient)=1, the other CC line=0.
- IDLE:
  - resp_req_out=1 captures auth_msg_resp_out into rx_msg.
  - Same edge: rx_cnt+1, Ack_out_resp=1 for one cycle, go to RESP_WAIT.
- RESP_WAIT:
  - After RESP_LAT cycles, auth_msg_resp_in<=table[rd_ptr] and resp_req_in<=1, go to RESP_DRIVE.
  - Latency: request sampled at edge N gives resp_req_in high after edge N+RESP_LAT.
- RESP_DRIVE:
  - resp_req_out sampled 0: resp_req_in<=0, rd_ptr<=rd_ptr+1 (wraps modulo DEPTH), go to IDLE.
  - TIMEOUT cycles without release: timeout_err<=1, resp_req_in<=0, rd_ptr advances, go to IDLE.
- Back-to-back requests: a request can only be re-captured in IDLE. resp_req_out must be seen low once in RESP_DRIVE before the next capture.
- auth_msg_resp_in holds its last value after resp_req_in falls.
- detach_cmd:
  - Accepted in any non-DETACHED state; next state DETACHED.
  - CC1, CC2, resp_req_in and Ack_out_resp go to 0 at the next edge.
  - Counters clear and rd_ptr is held.
- Simultaneous attach_cmd and detach_cmd: detach wins.
- attach_cmd outside DETACHED: ignored.
- resp_req_out while DETACHED or ATTACH_WAIT: ignored, not counted.
- Asynchronous reset mid-handshake: all outputs drop immediately, no Ack pulse.

Optional Feature:
- Macro: HOST_HDR_CHECK_EN.
- Defined:
  - On each capture, rx message bits [MSG_LEN-1:MSG_LEN-8] must equal 8'h01.
  - Mismatch sets hdr_err (sticky).
  - The response is still generated.
- Undefined: hdr_err tied to 0 and no compare logic is built.

Test Plan:
- Reset, attach_cmd with orient=0 -> CC1=1 exactly ATTACH_DLY=8 cycles later; CC2 stays 0.
- Attach with orient=1, table[0]=A, resp_req_out=1 at edge N -> Ack_out_resp pulse at N, resp_req_in=1 and auth_msg_resp_in=A after N+3, rx_cnt=1.
- Five request/release cycles with DEPTH=4 and table {A,B,C,D} -> responses A,B,C,D,A (wrap).
- Hold resp_req_out high 64 cycles in RESP_DRIVE -> timeout_err=1, resp_req_in=0, state IDLE, next response B.
- detach_cmd during RESP_WAIT -> CC lines=0 and resp_req_in=0 the next cycle. resp_req_out during DETACHED does not change rx_cnt.
- With HOST_HDR_CHECK_EN defined, controller message header 8'h02 -> hdr_err=1 and the response is still delivered. Header 8'h01 -> hdr_err stays 0.
